// File: rtl/seq_detect_param.sv
// Serial N-bit pattern detector with match counter; y is a Mealy pulse or arrives 1 cycle later (Moore).
// No backpressure: x is consumed on every x_valid edge, and idle cycles leave all state untouched.
module seq_detect_param #(
    parameter int             N       = 3,
    parameter logic [N-1:0]   PATTERN = 3'b101,
    parameter int             OVERLAP = 1,
    parameter int             MEALY   = 0,
    parameter int             CW      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   x,
    input  logic                   x_valid,
    input  logic                   restart,
    input  logic                   cnt_clr,
    output logic                   y,
    output logic [CW-1:0]          match_cnt,
    output logic [$clog2(N+1)-1:0] fill
);

    localparam int            FW       = $clog2(N+1);
    localparam logic [FW-1:0] FILL_MAX = FW'(N);
    localparam logic [FW-1:0] FILL_ARM = FW'(N-1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    logic [N-2:0]  r_hist;
    logic [FW-1:0] r_fill;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_win;
    logic          w_accept;
    logic          w_match;

    assign w_win    = {r_hist, x};
    assign w_accept = x_valid & ~restart;
    // A window only counts once N-1 real bits sit behind the incoming one.
    assign w_match  = w_accept & (w_win == PATTERN) & (r_fill >= FILL_ARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else if (w_accept) begin
            r_hist <= w_win[N-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
        end else if (restart) begin
            r_fill <= '0;
        end else if (w_accept) begin
            if ((OVERLAP == 0) && w_match) begin
                r_fill <= '0;
            end else if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        if (MEALY != 0) begin : g_mealy
            assign y = w_match & rst_n;
        end else begin : g_moore
            logic r_y;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y <= 1'b0;
                end else begin
                    r_y <= w_match;
                end
            end
            assign y = r_y;
        end
    endgenerate

    assign fill      = r_fill;
    assign match_cnt = r_cnt;

endmodule
